// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with 3-sample majority vote and FWFT receive FIFO
module uart_rx_fifo #(
    parameter int P_CLKS_PER_BIT = 434,
    parameter int P_FIFO_AW      = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 i_Rx,
    input  logic                 i_fRd,
    input  logic                 i_fClrErr,
    output logic [7:0]           o_Data,
    output logic                 o_fValid,
    output logic [P_FIFO_AW:0]   o_Count,
    output logic                 o_fFrameErr,
    output logic                 o_fOverrun,
    output logic                 o_fBusy
);

    localparam int H     = P_CLKS_PER_BIT / 2;
    localparam int CW    = $clog2(P_CLKS_PER_BIT);
    localparam int DEPTH = 1 << P_FIFO_AW;

    localparam logic [CW-1:0]      C_LAST = CW'(P_CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]      C_S0   = CW'(H - 1);
    localparam logic [CW-1:0]      C_S1   = CW'(H);
    localparam logic [CW-1:0]      C_DEC  = CW'(H + 1);
    localparam logic [P_FIFO_AW:0] C_FULL = (P_FIFO_AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic            rx_m;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;
    logic            smp0;
    logic            smp1;
    logic            maj;
    logic            decide;
    logic            push;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic [7:0]      mem [DEPTH];
    logic [P_FIFO_AW:0] wr_ptr;
    logic [P_FIFO_AW:0] rd_ptr;
    logic [P_FIFO_AW:0] count;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_Rx;
            rx_s <= rx_m;
        end
    end

    // Capture the first two of the three mid-bit samples; the third is rx_s itself
    always_ff @(posedge Clk) begin
        if (Rst) begin
            smp0 <= 1'b1;
            smp1 <= 1'b1;
        end else begin
            if (cnt == C_S0) smp0 <= rx_s;
            if (cnt == C_S1) smp1 <= rx_s;
        end
    end

    assign maj    = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign decide = (cnt == C_DEC);
    assign push   = (state == S_STOP) && decide && maj;

    // Receive FSM: bit timing, start validation, data shift and stop check
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_fFrameErr <= 1'b0;
        end else begin
            o_fFrameErr <= 1'b0;
            cnt         <= (cnt == C_LAST) ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (decide && maj) begin
                        state <= S_IDLE;
                    end else if (cnt == C_LAST) begin
                        state <= S_DATA;
                        idx   <= '0;
                    end
                end
                S_DATA: begin
                    if (decide) shreg[idx] <= maj;
                    if (cnt == C_LAST) begin
                        idx <= idx + 1'b1;
                        if (idx == 3'd7) state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (decide) begin
                        if (maj) begin
                            state <= S_IDLE;
                        end else begin
                            o_fFrameErr <= 1'b1;
                            state       <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == C_FULL);
    assign pop   = i_fRd && (count != '0);
    assign wr_en = push && (!full || pop);

    // FIFO storage; contents need no reset because pointers define validity
    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_ptr[P_FIFO_AW-1:0]] <= shreg;
    end

    // FIFO pointers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky overrun; a drop on the same cycle as a clear keeps the flag set
    always_ff @(posedge Clk) begin
        if (Rst) begin
            o_fOverrun <= 1'b0;
        end else if (push && full && !pop) begin
            o_fOverrun <= 1'b1;
        end else if (i_fClrErr) begin
            o_fOverrun <= 1'b0;
        end
    end

    assign o_fValid = (count != '0);
    assign o_Count  = count;
    assign o_Data   = o_fValid ? mem[rd_ptr[P_FIFO_AW-1:0]] : 8'h00;
    assign o_fBusy  = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int CPB   = 434;
    localparam int H     = CPB / 2;
    localparam int POP_K = H + 4;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       i_Rx = 1'b1;
    logic       i_fRd = 1'b0;
    logic       i_fClrErr = 1'b0;
    logic [7:0] o_Data;
    logic       o_fValid;
    logic [2:0] o_Count;
    logic       o_fFrameErr;
    logic       o_fOverrun;
    logic       o_fBusy;

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cnt = 0;
    int cyc = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(.P_CLKS_PER_BIT(CPB), .P_FIFO_AW(2)) dut (
        .Clk(Clk), .Rst(Rst), .i_Rx(i_Rx), .i_fRd(i_fRd), .i_fClrErr(i_fClrErr),
        .o_Data(o_Data), .o_fValid(o_fValid), .o_Count(o_Count),
        .o_fFrameErr(o_fFrameErr), .o_fOverrun(o_fOverrun), .o_fBusy(o_fBusy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) if (o_fFrameErr) fe_cnt = fe_cnt + 1;

    // Serial frame driver; optionally pops on the exact stop-bit decision cycle
    task automatic send_byte(input logic [7:0] b, input bit keep, input bit stop_val,
                             input int stop_bits, input bit pop_at_stop);
        if (keep) exp_q.push_back(b);
        @(negedge Clk);
        i_Rx = 1'b0;
        repeat (CPB) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            i_Rx = b[i];
            repeat (CPB) @(negedge Clk);
        end
        i_Rx = stop_val;
        for (int k = 1; k <= CPB * stop_bits; k++) begin
            @(negedge Clk);
            if (pop_at_stop && k == POP_K) begin
                n_cmp++;
                if (o_Data !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL pop_at_push_head got=%h exp=%h", o_Data, exp_q[0]);
                end
                void'(exp_q.pop_front());
                i_fRd = 1'b1;
            end else begin
                i_fRd = 1'b0;
            end
        end
        i_Rx = 1'b1;
    endtask

    task automatic pop_one(output logic [7:0] d, output logic v);
        @(negedge Clk);
        d = o_Data;
        v = o_fValid;
        i_fRd = 1'b1;
        @(negedge Clk);
        i_fRd = 1'b0;
    endtask

    task automatic drain(input int n, input string tag);
        logic [7:0] d;
        logic v;
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            pop_one(d, v);
            n_cmp++;
            if (v !== 1'b1 || d !== e) begin
                n_bad++;
                $display("FAIL %s_pop%0d got=%h valid=%b exp=%h", tag, i, d, v, e);
            end
        end
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if ({o_Data, o_fValid, o_Count, o_fFrameErr, o_fOverrun, o_fBusy} !== 14'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {o_Data, o_fValid, o_Count, o_fFrameErr, o_fOverrun, o_fBusy});
        end
    endtask

    task automatic test_basic;
        int fe0;
        fe0 = fe_cnt;
        send_byte(8'h3C, 1, 1, 1, 0);
        n_cmp++;
        if (o_Count !== 3'd1) begin n_bad++; $display("FAIL basic_count1 got=%0d exp=1", o_Count); end
        send_byte(8'hE5, 1, 1, 1, 0);
        n_cmp++;
        if (o_Count !== 3'd2) begin n_bad++; $display("FAIL basic_count2 got=%0d exp=2", o_Count); end
        n_cmp++;
        if (fe_cnt != fe0 || o_fOverrun !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_flags fe=%0d ovr=%b exp fe=0 ovr=0", fe_cnt - fe0, o_fOverrun);
        end
        drain(2, "basic");
    endtask

    task automatic test_false_start;
        int fe0;
        int rise;
        fe0 = fe_cnt;
        rise = -1;
        @(negedge Clk);
        i_Rx = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (o_fBusy && rise < 0) rise = cyc;
        end
        i_Rx = 1'b1;
        n_cmp++;
        if (rise < 0) begin n_bad++; $display("FAIL false_start_busy_rise got=0 exp=1"); rise = cyc; end
        while (o_fBusy && (cyc - rise) <= H + 4) @(negedge Clk);
        n_cmp++;
        if (o_fBusy !== 1'b0) begin n_bad++; $display("FAIL false_start_busy got=%b exp=0", o_fBusy); end
        repeat (10) @(negedge Clk);
        n_cmp++;
        if (o_Count !== 3'd0 || fe_cnt != fe0) begin
            n_bad++;
            $display("FAIL false_start_state count=%0d fe=%0d exp count=0 fe=0", o_Count, fe_cnt - fe0);
        end
    endtask

    task automatic test_frame_err;
        int fe0;
        fe0 = fe_cnt;
        send_byte(8'hA5, 0, 0, 2, 0);
        repeat (CPB) @(negedge Clk);
        n_cmp++;
        if (fe_cnt - fe0 != 1) begin n_bad++; $display("FAIL frame_err_pulses got=%0d exp=1", fe_cnt - fe0); end
        n_cmp++;
        if (o_Count !== 3'd0 || o_fBusy !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_err_state count=%0d busy=%b exp 0 0", o_Count, o_fBusy);
        end
        send_byte(8'h5A, 1, 1, 1, 0);
        drain(1, "after_fe");
    endtask

    task automatic test_overrun;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), (i <= 4), 1, 1, 0);
        n_cmp++;
        if (o_Count !== 3'd4 || o_fOverrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_state count=%0d ovr=%b exp 4 1", o_Count, o_fOverrun);
        end
        drain(4, "overrun");
        n_cmp++;
        if (o_fValid !== 1'b0) begin n_bad++; $display("FAIL overrun_empty got=%b exp=0", o_fValid); end
        @(negedge Clk);
        i_fClrErr = 1'b1;
        @(negedge Clk);
        i_fClrErr = 1'b0;
        n_cmp++;
        if (o_fOverrun !== 1'b0) begin n_bad++; $display("FAIL overrun_clear got=%b exp=0", o_fOverrun); end
    endtask

    task automatic test_full_pop;
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1, 1, 1, 0);
        n_cmp++;
        if (o_Count !== 3'd4) begin n_bad++; $display("FAIL full_fill got=%0d exp=4", o_Count); end
        send_byte(8'h15, 1, 1, 1, 1);
        n_cmp++;
        if (o_Count !== 3'd4 || o_fOverrun !== 1'b0) begin
            n_bad++;
            $display("FAIL full_pop_state count=%0d ovr=%b exp 4 0", o_Count, o_fOverrun);
        end
        drain(3, "full_pop");
        n_cmp++;
        if (o_fValid !== 1'b1 || o_Data !== 8'h15) begin
            n_bad++;
            $display("FAIL full_pop_head got=%h valid=%b exp=15", o_Data, o_fValid);
        end
    endtask

    task automatic test_reset_midframe;
        @(negedge Clk);
        i_Rx = 1'b0;
        repeat (CPB) @(negedge Clk);
        i_Rx = 1'b1;
        repeat (4 * CPB + 200) @(negedge Clk);
        n_cmp++;
        if (o_fBusy !== 1'b1) begin n_bad++; $display("FAIL midframe_busy got=%b exp=1", o_fBusy); end
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        exp_q.delete();
        n_cmp++;
        if ({o_Data, o_fValid, o_Count, o_fFrameErr, o_fOverrun, o_fBusy} !== 14'h0) begin
            n_bad++;
            $display("FAIL midframe_reset_outputs got=%h exp=0",
                     {o_Data, o_fValid, o_Count, o_fFrameErr, o_fOverrun, o_fBusy});
        end
        repeat (5 * CPB) @(negedge Clk);
        send_byte(8'h3C, 1, 1, 1, 0);
        n_cmp++;
        if (o_Count !== 3'd1) begin n_bad++; $display("FAIL midframe_count got=%0d exp=1", o_Count); end
        drain(1, "midframe");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Robust UART receiver with a 3-sample majority vote per bit, false-start rejection, framing-error detection and a small FWFT receive FIFO.
- Sits on the host-facing Rx pin of UART_Top-class designs and receives the byte stream that UART_TX produces (8N1, LSB first).
- Decouples byte arrival from the consumer via a ready/valid pop interface.
- Flags dropped bytes as overrun.

Parameters:
- P_CLKS_PER_BIT, 434, Clk cycles per bit (50 MHz / 115200); must be >= 8.
- P_FIFO_AW, 2, FIFO address width; depth = 2**P_FIFO_AW (default 4).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- i_Rx  in  1  asynchronous serial input; idle high.
- i_fRd  in  1  pop head byte; honoured only when o_fValid=1.
- i_fClrErr  in  1  clears o_fOverrun.
- o_Data  out  8  FIFO head byte; valid when o_fValid=1.
- o_fValid  out  1  FIFO not empty.
- o_Count  out  P_FIFO_AW+1  bytes held, 0..depth.
- o_fFrameErr  out  1  one-cycle pulse on a bad stop bit.
- o_fOverrun  out  1  sticky; a byte was dropped because the FIFO was full.
- o_fBusy  out  1  receive FSM not in IDLE.

Behaviour:

Reset:
- Reset (Rst=1 at a rising Clk edge) has priority over all other activity.
- All outputs go to 0; FSM goes to IDLE; FIFO is emptied.
- Both synchronizer flops are set to 1.
- A frame in progress is discarded; no partial byte enters the FIFO.

Input synchronizer and sampling:
- i_Rx passes through 2 flops; rx_s is the second flop.
- Bit counter cnt counts 0..P_CLKS_PER_BIT-1, restarts at 0 on each bit boundary.
- Samples are taken at cnt = H-1, H, H+1, where H = P_CLKS_PER_BIT/2 (integer division).
- Bit value is the majority of the 3 samples, registered at cnt = H+1.

FSM states:
- IDLE: o_fBusy=0. When rx_s=0, cnt<=0 and go to START.
- START: at cnt=H+1, if majority=1 it is a false start: go to IDLE with no error. Otherwise continue; at cnt=P_CLKS_PER_BIT-1 go to DATA with bit index 0.
- DATA: at cnt=H+1, shift the majority value into bit[index] (LSB first). After index 7 completes its full bit period, go to STOP.
- STOP, majority=1 at cnt=H+1: push the byte and go to IDLE immediately (half-bit early, for back-to-back frames).
- STOP, majority=0 at cnt=H+1: pulse o_fFrameErr for 1 cycle, discard the byte, go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. A held-low line produces exactly one o_fFrameErr.

Latency:
- The pushed byte is visible (o_fValid=1, o_Count incremented) on the cycle after the STOP decision edge.

FIFO (first-word fall-through):
- o_Data = mem[rd_ptr] combinationally from the registered pointer.
- Pointers are P_FIFO_AW+1 bits wide; wrap at 2**P_FIFO_AW is natural.
- Pop: i_fRd=1 and count>0 advances rd_ptr. i_fRd while empty is ignored; count never underflows.
- Push while count<depth: write, then advance wr_ptr.
- Push while full with simultaneous pop: both occur; count stays at depth; no overrun.
- Push while full without pop: byte dropped; o_fOverrun<=1; FIFO contents unchanged.
- o_fOverrun clears on i_fClrErr=1. If a set and a clear occur on the same cycle, set wins.

Test Plan:
- Basic receive: drive 8'h3C then 8'hE5 back-to-back from the UART_TX model at 434 clk/bit. Require o_Count 1 then 2. Pops return 3C then E5. No error flags.
- False start: pulse i_Rx low for 100 clks, then high. Require o_fBusy to return to 0 within H+4 clks, o_Count=0, no o_fFrameErr.
- Framing error: send 8'hA5 with the stop bit forced to 0 for 2 bit times, then idle. Require exactly one o_fFrameErr pulse and o_Count=0. A following frame 8'h5A is received correctly.
- Overrun: send 0x01..0x05 without popping. Require o_Count=4, o_fOverrun=1, pops return 01,02,03,04. After i_fClrErr, o_fOverrun=0.
- Full with simultaneous pop: FIFO full holding 0x11..0x14; assert i_fRd on the exact push cycle of 0x15. Require o_Count=4, o_fOverrun=0, subsequent pops 12,13,14,15.
- Reset mid-frame: assert Rst for 1 cycle during DATA bit 4 of 8'hFF, then send 8'h3C. Require the FIFO to hold only 3C, and all outputs 0 on the cycle after reset.
